product_accumulator: RTL and testbench

//   Downstream consumer of the 2-bit multiplier's 4-bit product {Co,S[2:0]} (range 0..9).
//   - Accepts one product per beat over a valid/ready handshake.
//   - Sums N_PROD products into an ACC_W-bit batch result.
//   - Presents the result over a valid/ready output with an overflow flag.
//   - Turns the combinational multiplier into a small MAC-style datapath stage.

---
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Batch accumulator for the 2-bit multiplier's 4-bit product: sums N_PROD products and presents
// the result with an overflow flag over valid/ready. Define PRODACC_SATURATE_EN to saturate on overflow.
module product_accumulator #(
    parameter int ACC_W  = 8,
    parameter int N_PROD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       prod,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PROD - 1);

    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic [ACC_W:0]   sum;
    logic             ovf_next;
    logic [ACC_W-1:0] acc_next;
    logic             accept;

    assign in_ready = (state == S_ACC) & ~clr;
    assign accept   = in_valid & in_ready;

    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W-3){1'b0}}, prod};
        ovf_next = sticky | sum[ACC_W];
`ifdef PRODACC_SATURATE_EN
        // Once overflowed, acc is pinned at all-ones for the remainder of the batch.
        acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            acc_out   <= acc_next;
                            ovf       <= ovf_next;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                            acc       <= '0;
                            cnt       <= '0;
                            sticky    <= 1'b0;
                        end else begin
                            acc    <= acc_next;
                            sticky <= ovf_next;
                            cnt    <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: default, ACC_W=4 and N_PROD=1 instances share clock and reset.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance 0: defaults
    logic [3:0] prod0;
    logic       iv0, ir0, clr0, ov0, ovf0, ordy0;
    logic [7:0] acc0;
    // instance 1: ACC_W=4
    logic [3:0] prod1;
    logic       iv1, ir1, clr1, ov1, ovf1, ordy1;
    logic [3:0] acc1;
    // instance 2: N_PROD=1
    logic [3:0] prod2;
    logic       iv2, ir2, clr2, ov2, ovf2, ordy2;
    logic [7:0] acc2;

    product_accumulator dut0 (
        .clk(clk), .rst_n(rst_n), .prod(prod0), .in_valid(iv0), .in_ready(ir0), .clr(clr0),
        .acc_out(acc0), .ovf(ovf0), .out_valid(ov0), .out_ready(ordy0));
    product_accumulator #(.ACC_W(4), .N_PROD(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .prod(prod1), .in_valid(iv1), .in_ready(ir1), .clr(clr1),
        .acc_out(acc1), .ovf(ovf1), .out_valid(ov1), .out_ready(ordy1));
    product_accumulator #(.ACC_W(8), .N_PROD(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .prod(prod2), .in_valid(iv2), .in_ready(ir2), .clr(clr2),
        .acc_out(acc2), .ovf(ovf2), .out_valid(ov2), .out_ready(ordy2));

    int vecs = 0;
    int errs = 0;
    int q0[$];
    int q1[$];
    int q2[$];

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected entries encode {ovf, acc_out} as ovf*256 + acc.
    always @(negedge clk) begin
        if (rst_n && ov0 && ordy0) begin
            if (q0.size() == 0) chk("dut0_unexpected_result", int'(acc0), -1);
            else begin
                int e;
                e = q0.pop_front();
                chk("dut0_acc_out", int'(acc0), e % 256);
                chk("dut0_ovf", int'(ovf0), e / 256);
            end
        end
        if (rst_n && ov1 && ordy1) begin
            if (q1.size() == 0) chk("dut1_unexpected_result", int'(acc1), -1);
            else begin
                int e;
                e = q1.pop_front();
                chk("dut1_acc_out", int'(acc1), e % 256);
                chk("dut1_ovf", int'(ovf1), e / 256);
            end
        end
        if (rst_n && ov2 && ordy2) begin
            if (q2.size() == 0) chk("dut2_unexpected_result", int'(acc2), -1);
            else begin
                int e;
                e = q2.pop_front();
                chk("dut2_acc_out", int'(acc2), e % 256);
                chk("dut2_ovf", int'(ovf2), e / 256);
            end
        end
    end

    task automatic send0(input logic [3:0] p);
        bit done;
        done = 1'b0;
        prod0 = p;
        iv0   = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ir0) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        iv0 = 1'b0;
        if (!done) chk("dut0_send_timeout", 0, 1);
    endtask

    task automatic send1(input logic [3:0] p);
        bit done;
        done = 1'b0;
        prod1 = p;
        iv1   = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ir1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        iv1 = 1'b0;
        if (!done) chk("dut1_send_timeout", 0, 1);
    endtask

    initial begin
        int sat_exp;
        int prev_ov;
        rst_n = 1'b0;
        prod0 = '0; iv0 = 1'b0; clr0 = 1'b0; ordy0 = 1'b1;
        prod1 = '0; iv1 = 1'b0; clr1 = 1'b0; ordy1 = 1'b1;
        prod2 = '0; iv2 = 1'b0; clr2 = 1'b0; ordy2 = 1'b1;
        #1;
        chk("reset_acc_out", int'(acc0), 0);
        chk("reset_ovf", int'(ovf0), 0);
        chk("reset_out_valid", int'(ov0), 0);
        chk("reset_in_ready", int'(ir0), 1);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back batch, result latency and single-cycle in_ready drop
        q0.push_back(19);
        send0(4'd9); send0(4'd6); send0(4'd3); send0(4'd1);
        chk("t1_out_valid_after_close", int'(ov0), 1);
        chk("t1_in_ready_low", int'(ir0), 0);
        @(posedge clk); #1;
        chk("t1_out_valid_cleared", int'(ov0), 0);
        chk("t1_in_ready_back", int'(ir0), 1);

        // output backpressure with a pending producer beat
        ordy0 = 1'b0;
        q0.push_back(10);
        send0(4'd1); send0(4'd2); send0(4'd3); send0(4'd4);
        prod0 = 4'd2;
        iv0   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_in_ready_stalled", int'(ir0), 0);
            chk("t2_acc_out_stable", int'(acc0), 10);
            chk("t2_out_valid_held", int'(ov0), 1);
        end
        @(posedge clk); #1;
        ordy0 = 1'b1;
        iv0   = 1'b0;
        @(posedge clk); #1;
        chk("t2_in_ready_after_release", int'(ir0), 1);

        // clr aborts a partial batch and does not consume the beat it sees
        send0(4'd5); send0(4'd5);
        prod0 = 4'd7; iv0 = 1'b1; clr0 = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_during_clr", int'(ir0), 0);
        @(posedge clk); #1;
        clr0 = 1'b0; iv0 = 1'b0;
        q0.push_back(4);
        send0(4'd1); send0(4'd1); send0(4'd1); send0(4'd1);
        @(posedge clk); #1;

        // asynchronous reset mid-batch, then while holding a result
        send0(4'd3); send0(4'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_mid_acc_out", int'(acc0), 0);
        chk("t5_mid_out_valid", int'(ov0), 0);
        chk("t5_mid_in_ready", int'(ir0), 1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ordy0 = 1'b0;
        send0(4'd7); send0(4'd7); send0(4'd7); send0(4'd7);
        chk("t5_done_acc_out", int'(acc0), 28);
        chk("t5_done_out_valid", int'(ov0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_done_rst_acc_out", int'(acc0), 0);
        chk("t5_done_rst_out_valid", int'(ov0), 0);
        chk("t5_done_rst_ovf", int'(ovf0), 0);
        #1 rst_n = 1'b1;
        ordy0 = 1'b1;
        @(posedge clk); #1;
        q0.push_back(8);
        send0(4'd2); send0(4'd2); send0(4'd2); send0(4'd2);

        // ACC_W=4: overflow, exact full-scale, and sticky flag cleared between batches
`ifdef PRODACC_SATURATE_EN
        sat_exp = 256 + 15;
`else
        sat_exp = 256 + 4;
`endif
        q1.push_back(sat_exp);
        send1(4'd9); send1(4'd9); send1(4'd9); send1(4'd9);
        q1.push_back(15);
        send1(4'd9); send1(4'd6); send1(4'd0); send1(4'd0);
        q1.push_back(10);
        send1(4'd1); send1(4'd2); send1(4'd3); send1(4'd4);

        // N_PROD=1 streaming: a result every other cycle
        prod2 = 4'd6;
        iv2   = 1'b1;
        prev_ov = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (iv2 && ir2) q2.push_back(6);
            if (i > 0) chk("t6_out_valid_alternates", int'(ov2), 1 - prev_ov);
            prev_ov = int'(ov2);
        end
        @(posedge clk); #1;
        iv2 = 1'b0;

        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            @(posedge clk);
        chk("dut0_results_drained", q0.size(), 0);
        chk("dut1_results_drained", q1.size(), 0);
        chk("dut2_results_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
